// File: rtl/fractal_pkg.sv
// Shared constants and state encoding for the fractal pixel scheduler.
package fractal_pkg;
    localparam int X_SIZE_DEF = 640;
    localparam int Y_SIZE_DEF = 480;
    localparam int X_W        = 10;
    localparam int Y_W        = 9;
    localparam int ITER_W     = 8;
    localparam int TOTAL_W    = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } sched_state_t;
endpackage

// File: rtl/fractal_coord_counter.sv
// Raster x/y counter: x wraps at X_SIZE-1 and carries into y; exposes last-column/last-line flags.
module fractal_coord_counter
    import fractal_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           inc,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           x_last,
    output logic           y_last
);
    assign x_last = (x == X_W'(X_SIZE - 1));
    assign y_last = (y == Y_W'(Y_SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fractal_pixel_scheduler.sv
// Round-robin dispatch of one frame across N_ENGINES iteration engines, in-order retire to the packer.
// Build option: define SCHED_CONTINUOUS_EN to restart the next frame immediately after the last pixel.
module fractal_pixel_scheduler
    import fractal_pkg::*;
#(
    parameter int N_ENGINES = 4,
    parameter int X_SIZE    = X_SIZE_DEF,
    parameter int Y_SIZE    = Y_SIZE_DEF
) (
    input  logic                          out_stream_aclk,
    input  logic                          periph_resetn,
    input  logic                          cfg_start,
    output logic                          status_busy,
    output logic                          frame_done,
    output logic [15:0]                   frame_count,
    output logic [N_ENGINES-1:0]          eng_start,
    output logic [X_W-1:0]                eng_x,
    output logic [Y_W-1:0]                eng_y,
    input  logic [N_ENGINES-1:0]          eng_done,
    input  logic [ITER_W*N_ENGINES-1:0]   eng_iter,
    output logic [N_ENGINES-1:0]          eng_ack,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [ITER_W-1:0]             pix_iter,
    output logic                          pix_sof,
    output logic                          pix_eol
);
    localparam int                 PTR_W      = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
    localparam logic [PTR_W-1:0]   PTR_MAX    = PTR_W'(N_ENGINES - 1);
    localparam logic [TOTAL_W-1:0] TOTAL_LAST = TOTAL_W'(X_SIZE * Y_SIZE - 1);

    sched_state_t         state;
    logic [N_ENGINES-1:0] busy;
    logic [PTR_W-1:0]     disp_ptr, ret_ptr;
    logic [TOTAL_W-1:0]   disp_total;
    logic                 pix_last;
    logic                 disp_fire, ret_load, last_accept;
    logic [X_W-1:0]       ret_x;
    logic [Y_W-1:0]       ret_y;
    logic                 ret_x_last, ret_y_last;
    logic [1:0]           disp_flags_unused;

    assign status_busy = (state != ST_IDLE);
    assign disp_fire   = (state == ST_RUN) && !busy[disp_ptr];
    assign ret_load    = (state != ST_IDLE) && busy[ret_ptr] && eng_done[ret_ptr]
                         && (!pix_valid || pix_ready);
    assign last_accept = pix_valid && pix_ready && pix_last;
    assign frame_done  = last_accept;

    for (genvar k = 0; k < N_ENGINES; k++) begin : g_lane
        assign eng_start[k] = disp_fire && (disp_ptr == PTR_W'(k));
        assign eng_ack[k]   = ret_load  && (ret_ptr  == PTR_W'(k));
    end

    fractal_coord_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_disp_cnt (
        .clk    (out_stream_aclk),
        .rst_n  (periph_resetn),
        .clr    (last_accept),
        .inc    (disp_fire),
        .x      (eng_x),
        .y      (eng_y),
        .x_last (disp_flags_unused[0]),
        .y_last (disp_flags_unused[1])
    );

    fractal_coord_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_ret_cnt (
        .clk    (out_stream_aclk),
        .rst_n  (periph_resetn),
        .clr    (last_accept),
        .inc    (ret_load),
        .x      (ret_x),
        .y      (ret_y),
        .x_last (ret_x_last),
        .y_last (ret_y_last)
    );

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state       <= ST_IDLE;
            busy        <= '0;
            disp_ptr    <= '0;
            ret_ptr     <= '0;
            disp_total  <= '0;
            pix_valid   <= 1'b0;
            pix_iter    <= '0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            pix_last    <= 1'b0;
            frame_count <= '0;
        end else begin
            busy <= (busy | eng_start) & ~eng_ack;

            if (disp_fire) begin
                disp_ptr   <= (disp_ptr == PTR_MAX) ? '0 : disp_ptr + 1'b1;
                disp_total <= disp_total + 1'b1;
            end

            // Output register: reload in the same cycle the held pixel drains.
            if (ret_load) begin
                ret_ptr   <= (ret_ptr == PTR_MAX) ? '0 : ret_ptr + 1'b1;
                pix_valid <= 1'b1;
                pix_iter  <= eng_iter[ret_ptr*ITER_W +: ITER_W];
                pix_sof   <= (ret_x == '0) && (ret_y == '0);
                pix_eol   <= ret_x_last;
                pix_last  <= ret_x_last && ret_y_last;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end

            case (state)
                ST_IDLE:  if (cfg_start) state <= ST_RUN;
                ST_RUN:   if (disp_fire && (disp_total == TOTAL_LAST)) state <= ST_DRAIN;
                ST_DRAIN: if (last_accept) begin
`ifdef SCHED_CONTINUOUS_EN
                    state <= ST_RUN;
`else
                    state <= ST_IDLE;
`endif
                end
                default:  state <= ST_IDLE;
            endcase

            if (last_accept) begin
                frame_count <= frame_count + 1'b1;
                busy        <= '0;
                disp_ptr    <= '0;
                ret_ptr     <= '0;
                disp_total  <= '0;
            end
        end
    end
endmodule
